str_gbox_frac: RTL and testbench

Arbitrary-ratio stream gearbox that repacks a valid/ready stream of `UP_WIDTH`-bit words into `DN_WIDTH`-bit words. The widths need not divide each other. Bits pack LSB-first, so the oldest bit is always at `dn_data[0]`. `up_last` flushes a zero-padded partial word. It replaces fixed integer-ratio gearboxes between the DMA streams and the conv-engine line buffers, where word widths such as 12↔8 or 24↔16 occur.

---
 rtl/str_pkg.sv | 18 +
 rtl/str_gbox_frac_if.sv | 35 +++
 rtl/str_gbox_frac.sv | 95 +++++++++
 tb/tb_str_gbox_frac.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/str_pkg.sv
// Shared stream helpers: buffer-width arithmetic and the handshake control pair.
package str_pkg;

  // Control half of a data/last/val beat; data width is chosen per instance.
  typedef struct packed {
    logic last;
    logic val;
  } str_ctl_t;

  function automatic int unsigned str_max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned str_gbox_buf_w(int unsigned up, int unsigned dn);
    return up + 2 * dn;
  endfunction

endpackage

// File: rtl/str_gbox_frac_if.sv
// Upstream/downstream handshake bundle for str_gbox_frac.
// dn_cnt exists only when STR_GBOX_CNT_EN is defined.
interface str_gbox_frac_if #(
  parameter int unsigned UP_WIDTH = 12,
  parameter int unsigned DN_WIDTH = 8
);
  logic [UP_WIDTH-1:0] up_data;
  logic                up_last;
  logic                up_val;
  logic                up_rdy;
  logic [DN_WIDTH-1:0] dn_data;
  logic                dn_last;
  logic                dn_val;
  logic                dn_rdy;
`ifdef STR_GBOX_CNT_EN
  localparam int unsigned CNT_W = $clog2(DN_WIDTH + 1);
  logic [CNT_W-1:0]    dn_cnt;
`endif

  modport master (
    output up_data, up_last, up_val, dn_rdy,
    input  up_rdy, dn_data, dn_last, dn_val
`ifdef STR_GBOX_CNT_EN
    , input dn_cnt
`endif
  );

  modport slave (
    input  up_data, up_last, up_val, dn_rdy,
    output up_rdy, dn_data, dn_last, dn_val
`ifdef STR_GBOX_CNT_EN
    , output dn_cnt
`endif
  );
endinterface

// File: rtl/str_gbox_frac.sv
// Arbitrary-ratio LSB-first stream gearbox; up_last flushes a zero-padded partial word.
// Optional dn_cnt valid-length port is enabled by defining STR_GBOX_CNT_EN.
module str_gbox_frac
  import str_pkg::*;
#(
  parameter int unsigned UP_WIDTH = 12,
  parameter int unsigned DN_WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  str_gbox_frac_if.slave bus
);

  localparam int unsigned       BUF_W   = str_gbox_buf_w(UP_WIDTH, DN_WIDTH);
  localparam int unsigned       FILL_W  = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] DN_F    = FILL_W'(DN_WIDTH);
  localparam logic [FILL_W-1:0] UP_F    = FILL_W'(UP_WIDTH);
  localparam logic [FILL_W-1:0] RDY_MAX = FILL_W'(BUF_W - UP_WIDTH);

  logic [BUF_W-1:0]  buf_q, buf_nx;
  logic [FILL_W-1:0] fill_q, fill_nx, take;
  logic              flush_q, flush_nx;
  logic              up_rdy_q, up_rdy_nx;
  logic              up_fire, dn_fire;
  str_ctl_t          dn_q, dn_nx;

  // Drain and load in one shift expression; arriving bits land above the residue.
  always_comb begin
    up_fire  = bus.up_val & up_rdy_q;
    dn_fire  = dn_q.val & bus.dn_rdy;
    take     = '0;
    if (dn_fire) begin
      take = (fill_q < DN_F) ? fill_q : DN_F;
    end
    buf_nx  = buf_q >> take;
    fill_nx = fill_q - take;
    if (up_fire) begin
      buf_nx  = buf_nx | (BUF_W'(bus.up_data) << fill_nx);
      fill_nx = fill_nx + UP_F;
    end
    flush_nx = flush_q;
    if (dn_fire && dn_q.last) begin
      flush_nx = 1'b0;
    end
    if (up_fire && bus.up_last) begin
      flush_nx = 1'b1;
    end
    // Outputs are decoded from next-state so they leave the block registered.
    dn_nx.val  = (fill_nx >= DN_F) | (flush_nx & (fill_nx != '0));
    dn_nx.last = flush_nx & (fill_nx <= DN_F);
    up_rdy_nx  = ~flush_nx & (fill_nx <= RDY_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q    <= '0;
      fill_q   <= '0;
      flush_q  <= 1'b0;
      up_rdy_q <= 1'b1;
      dn_q     <= '0;
    end else begin
      buf_q    <= buf_nx;
      fill_q   <= fill_nx;
      flush_q  <= flush_nx;
      up_rdy_q <= up_rdy_nx;
      dn_q     <= dn_nx;
    end
  end

  assign bus.up_rdy  = up_rdy_q;
  assign bus.dn_val  = dn_q.val;
  assign bus.dn_last = dn_q.last;
  assign bus.dn_data = buf_q[DN_WIDTH-1:0];

`ifdef STR_GBOX_CNT_EN
  localparam int unsigned CNT_W = $clog2(DN_WIDTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_nx;

  assign cnt_nx = (fill_nx < DN_F) ? CNT_W'(fill_nx) : CNT_W'(DN_WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nx;
    end
  end

  assign bus.dn_cnt = cnt_q;
`else
  // No length port: consumers take the valid length from packet metadata.
`endif

endmodule

// File: tb/tb_str_gbox_frac.sv
// Self-checking bench for str_gbox_frac at 12->8, 2->8 and 8->12 against a bit-queue model.
module tb_str_gbox_frac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cnt;
  } exp_t;

  bit   mbits[$];
  exp_t mexp[$];
  int   mup = 12;
  int   mdn = 8;

  logic        f_up, f_dn, o_val, o_urdy, o_last;
  logic [31:0] o_data;
  int          o_fill;
`ifdef STR_GBOX_CNT_EN
  int          o_cnt;
`endif

  str_gbox_frac_if #(.UP_WIDTH(12), .DN_WIDTH(8))  ia ();
  str_gbox_frac_if #(.UP_WIDTH(2),  .DN_WIDTH(8))  ib ();
  str_gbox_frac_if #(.UP_WIDTH(8),  .DN_WIDTH(12)) ic ();

  str_gbox_frac #(.UP_WIDTH(12), .DN_WIDTH(8))  u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  str_gbox_frac #(.UP_WIDTH(2),  .DN_WIDTH(8))  u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  str_gbox_frac #(.UP_WIDTH(8),  .DN_WIDTH(12)) u_c (.clk(clk), .rst(rst), .bus(ic.slave));

  // Reference: a packet is a bit string cut into DN-bit words, last word zero-padded.
  function automatic void model_reset(int up, int dn);
    mup = up;
    mdn = dn;
    mbits.delete();
    mexp.delete();
  endfunction

  function automatic void model_push(logic [31:0] d, logic l);
    exp_t e;
    for (int i = 0; i < mup; i++) mbits.push_back(d[i]);
    while (mbits.size() >= mdn) begin
      e.data = '0;
      for (int i = 0; i < mdn; i++) e.data[i] = mbits.pop_front();
      e.cnt  = mdn;
      e.last = l && (mbits.size() == 0);
      mexp.push_back(e);
    end
    if (l && mbits.size() != 0) begin
      e.data = '0;
      e.cnt  = mbits.size();
      e.last = 1'b1;
      for (int i = 0; i < e.cnt; i++) e.data[i] = mbits.pop_front();
      mexp.push_back(e);
    end
  endfunction

  task automatic idle_all();
    ia.up_val = 1'b0; ia.up_data = '0; ia.up_last = 1'b0; ia.dn_rdy = 1'b0;
    ib.up_val = 1'b0; ib.up_data = '0; ib.up_last = 1'b0; ib.dn_rdy = 1'b0;
    ic.up_val = 1'b0; ic.up_data = '0; ic.up_last = 1'b0; ic.dn_rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle at the falling edge, capture outputs and the fires of the coming edge.
  task automatic drv_a(input logic v, input logic [11:0] d, input logic l, input logic r);
    @(negedge clk);
    ia.up_val = v; ia.up_data = d; ia.up_last = l; ia.dn_rdy = r;
    o_val = ia.dn_val; o_urdy = ia.up_rdy; o_last = ia.dn_last;
    o_data = 32'(ia.dn_data);
    o_fill = int'(u_a.fill_q);
`ifdef STR_GBOX_CNT_EN
    o_cnt = int'(ia.dn_cnt);
`endif
    f_up = v & o_urdy;
    f_dn = o_val & r;
    @(posedge clk);
  endtask

  task automatic drv_b(input logic v, input logic [1:0] d, input logic l, input logic r);
    @(negedge clk);
    ib.up_val = v; ib.up_data = d; ib.up_last = l; ib.dn_rdy = r;
    o_val = ib.dn_val; o_urdy = ib.up_rdy; o_last = ib.dn_last;
    o_data = 32'(ib.dn_data);
    o_fill = int'(u_b.fill_q);
`ifdef STR_GBOX_CNT_EN
    o_cnt = int'(ib.dn_cnt);
`endif
    f_up = v & o_urdy;
    f_dn = o_val & r;
    @(posedge clk);
  endtask

  task automatic drv_c(input logic v, input logic [7:0] d, input logic l, input logic r);
    @(negedge clk);
    ic.up_val = v; ic.up_data = d; ic.up_last = l; ic.dn_rdy = r;
    o_val = ic.dn_val; o_urdy = ic.up_rdy; o_last = ic.dn_last;
    o_data = 32'(ic.dn_data);
    o_fill = int'(u_c.fill_q);
`ifdef STR_GBOX_CNT_EN
    o_cnt = int'(ic.dn_cnt);
`endif
    f_up = v & o_urdy;
    f_dn = o_val & r;
    @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (ia.up_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_a_up_rdy: got %b want 1", ia.up_rdy); end
    n_cmp++; if (ia.dn_val !== 1'b0) begin n_bad++; $display("FAIL reset_a_dn_val: got %b want 0", ia.dn_val); end
    n_cmp++; if (ia.dn_last !== 1'b0) begin n_bad++; $display("FAIL reset_a_dn_last: got %b want 0", ia.dn_last); end
    n_cmp++; if (ia.dn_data !== 8'h00) begin n_bad++; $display("FAIL reset_a_dn_data: got %h want 00", ia.dn_data); end
`ifdef STR_GBOX_CNT_EN
    n_cmp++; if (ia.dn_cnt !== '0) begin n_bad++; $display("FAIL reset_a_dn_cnt: got %0d want 0", ia.dn_cnt); end
`endif
    n_cmp++; if (ib.dn_val !== 1'b0 || ib.up_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_b: got val=%b rdy=%b want 0 1", ib.dn_val, ib.up_rdy); end
    n_cmp++; if (ic.dn_val !== 1'b0 || ic.up_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_c: got val=%b rdy=%b want 0 1", ic.dn_val, ic.up_rdy); end
  endtask

  task automatic test_no_stall();
    logic [11:0] din [2];
    logic [31:0] want [3];
    int got = 0;
    int k = 0;
    din  = '{12'hABC, 12'h123};
    want = '{32'hBC, 32'h3A, 32'h12};
    do_reset();
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (k < 2) drv_a(1'b1, din[k], 1'b0, 1'b1);
      else       drv_a(1'b0, '0, 1'b0, 1'b1);
      if (f_up) k++;
      if (f_dn) begin
        n_cmp++; if (o_data !== want[got] || o_last !== 1'b0) begin n_bad++; $display("FAIL no_stall_word%0d: got %h last=%b want %h last=0", got, o_data, o_last, want[got]); end
`ifdef STR_GBOX_CNT_EN
        n_cmp++; if (o_cnt !== 8) begin n_bad++; $display("FAIL no_stall_cnt%0d: got %0d want 8", got, o_cnt); end
`endif
        got++;
      end
    end
    n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL no_stall_count: got %0d words want 3", got); end
  endtask

  task automatic test_flush_2to8();
    logic [1:0] beats [3];
    int k = 0;
    beats = '{2'b01, 2'b10, 2'b11};
    do_reset();
    for (int c = 0; c < 20 && k < 3; c++) begin
      drv_b(1'b1, beats[k], (k == 2), 1'b0);
      if (f_up) k++;
    end
    n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL flush_accept: got %0d beats want 3", k); end
    for (int c = 0; c < 3; c++) begin
      drv_b(1'b1, 2'b11, 1'b0, 1'b0);
      n_cmp++; if (o_urdy !== 1'b0 || f_up !== 1'b0) begin n_bad++; $display("FAIL flush_up_rdy: got %b want 0", o_urdy); end
      n_cmp++; if (o_val !== 1'b1 || o_data !== 32'h39 || o_last !== 1'b1) begin n_bad++; $display("FAIL flush_word: got val=%b %h last=%b want val=1 39 last=1", o_val, o_data, o_last); end
`ifdef STR_GBOX_CNT_EN
      n_cmp++; if (o_cnt !== 6) begin n_bad++; $display("FAIL flush_cnt: got %0d want 6", o_cnt); end
`endif
    end
    drv_b(1'b1, 2'b11, 1'b0, 1'b1);
    n_cmp++; if (f_dn !== 1'b1 || f_up !== 1'b0) begin n_bad++; $display("FAIL flush_fire: got dn=%b up=%b want 1 0", f_dn, f_up); end
    drv_b(1'b0, 2'b00, 1'b0, 1'b1);
    n_cmp++; if (o_urdy !== 1'b1 || o_val !== 1'b0) begin n_bad++; $display("FAIL flush_done: got rdy=%b val=%b want 1 0", o_urdy, o_val); end
  endtask

  task automatic test_exact_multiple();
    logic [7:0]  din [3];
    logic [31:0] want [2];
    logic        wl [2];
    int got = 0;
    int k = 0;
    din  = '{8'h11, 8'h22, 8'h33};
    want = '{32'h211, 32'h332};
    wl   = '{1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 30 && got < 2; c++) begin
      if (k < 3) drv_c(1'b1, din[k], (k == 2), 1'b1);
      else       drv_c(1'b0, '0, 1'b0, 1'b1);
      if (f_up) k++;
      if (f_dn) begin
        n_cmp++; if (o_data !== want[got] || o_last !== wl[got]) begin n_bad++; $display("FAIL exact_word%0d: got %h last=%b want %h last=%b", got, o_data, o_last, want[got], wl[got]); end
`ifdef STR_GBOX_CNT_EN
        n_cmp++; if (o_cnt !== 12) begin n_bad++; $display("FAIL exact_cnt%0d: got %0d want 12", got, o_cnt); end
`endif
        got++;
      end
    end
    n_cmp++; if (got !== 2) begin n_bad++; $display("FAIL exact_count: got %0d words want 2", got); end
    for (int c = 0; c < 4; c++) begin
      drv_c(1'b0, '0, 1'b0, 1'b1);
      n_cmp++; if (o_val !== 1'b0) begin n_bad++; $display("FAIL exact_extra: got val=%b want 0", o_val); end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] din [6];
    exp_t        e;
    logic        hold = 1'b0;
    logic        hl = 1'b0;
    logic [31:0] hd = '0;
    logic        saw_low = 1'b0;
    int          tbf = 0;
    int          k = 0;
    logic        r;
    for (int i = 0; i < 6; i++) din[i] = 12'($urandom);
    do_reset();
    model_reset(12, 8);
    for (int c = 0; c < 80; c++) begin
      r = (c >= 10);
      drv_a(k < 6, din[(k < 6) ? k : 0], 1'b0, r);
      n_cmp++; if (o_urdy !== (tbf <= 16)) begin n_bad++; $display("FAIL bp_up_rdy: got %b want %b (fill %0d)", o_urdy, (tbf <= 16), tbf); end
      if (hold) begin
        n_cmp++; if (o_val !== 1'b1 || o_data !== hd || o_last !== hl) begin n_bad++; $display("FAIL bp_hold: got val=%b %h want val=1 %h", o_val, o_data, hd); end
      end
      hold = o_val & ~r; hd = o_data; hl = o_last;
      if (!o_urdy) saw_low = 1'b1;
      if (f_up) begin model_push(32'(din[k]), 1'b0); tbf += 12; k++; end
      if (f_dn) begin
        tbf -= 8;
        n_cmp++;
        if (mexp.size() == 0) begin n_bad++; $display("FAIL bp_extra: got %h want no word", o_data); end
        else begin
          e = mexp.pop_front();
          if (o_data !== e.data || o_last !== e.last) begin n_bad++; $display("FAIL bp_word: got %h last=%b want %h last=%b", o_data, o_last, e.data, e.last); end
        end
      end
      if (k == 6 && mexp.size() == 0 && c >= 10) break;
    end
    n_cmp++; if (k !== 6 || mexp.size() !== 0) begin n_bad++; $display("FAIL bp_timeout: got %0d beats %0d pending want 6 0", k, mexp.size()); end
    n_cmp++; if (saw_low !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_drop: got %b want 1", saw_low); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drv_a(1'b1, 12'hABC, 1'b0, 1'b0);
    drv_a(1'b1, 12'h5F0, 1'b0, 1'b1);
    n_cmp++; if (f_up !== 1'b1 || f_dn !== 1'b1 || o_data !== 32'hBC) begin n_bad++; $display("FAIL sim_fire: got up=%b dn=%b %h want 1 1 bc", f_up, f_dn, o_data); end
    n_cmp++; if (o_fill !== 12) begin n_bad++; $display("FAIL sim_fill_before: got %0d want 12", o_fill); end
    drv_a(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (o_fill !== 16 || o_data !== 32'h0A) begin n_bad++; $display("FAIL sim_after: got fill=%0d %h want 16 0a", o_fill, o_data); end
    drv_a(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (o_data !== 32'h5F || o_val !== 1'b1) begin n_bad++; $display("FAIL sim_tail: got val=%b %h want 1 5f", o_val, o_data); end
    drv_a(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (o_val !== 1'b0 || o_fill !== 0) begin n_bad++; $display("FAIL sim_empty: got val=%b fill=%0d want 0 0", o_val, o_fill); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] beats [4];
    int got = 0;
    int k = 0;
    beats = '{2'b11, 2'b00, 2'b10, 2'b01};
    do_reset();
    drv_b(1'b1, 2'b11, 1'b0, 1'b0);
    drv_b(1'b1, 2'b01, 1'b1, 1'b0);
    drv_b(1'b0, 2'b00, 1'b0, 1'b0);
    n_cmp++; if (o_fill !== 4 || o_val !== 1'b1 || o_last !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got fill=%0d val=%b last=%b want 4 1 1", o_fill, o_val, o_last); end
    do_reset();
    n_cmp++; if (ib.dn_val !== 1'b0 || ib.up_rdy !== 1'b1 || u_b.fill_q !== '0) begin n_bad++; $display("FAIL rmid_post: got val=%b rdy=%b fill=%0d want 0 1 0", ib.dn_val, ib.up_rdy, u_b.fill_q); end
    for (int c = 0; c < 20; c++) begin
      if (k < 4) drv_b(1'b1, beats[k], (k == 3), 1'b1);
      else       drv_b(1'b0, 2'b00, 1'b0, 1'b1);
      if (f_up) k++;
      if (f_dn) begin
        got++;
        n_cmp++; if (o_data !== 32'h63 || o_last !== 1'b1) begin n_bad++; $display("FAIL rmid_word: got %h last=%b want 63 last=1", o_data, o_last); end
`ifdef STR_GBOX_CNT_EN
        n_cmp++; if (o_cnt !== 8) begin n_bad++; $display("FAIL rmid_cnt: got %0d want 8", o_cnt); end
`endif
      end
    end
    n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL rmid_count: got %0d words want 1", got); end
  endtask

  task automatic test_random();
    exp_t        e;
    logic        v, l, r;
    logic [11:0] d;
    logic        hold = 1'b0;
    logic        hl = 1'b0;
    logic [31:0] hd = '0;
    logic        mfl = 1'b0;
    logic        tail_done = 1'b0;
    do_reset();
    model_reset(12, 8);
    for (int c = 0; c < 900; c++) begin
      d = 12'($urandom);
      if (c < 400) begin
        v = ($urandom_range(0, 3) != 0);
        l = ($urandom_range(0, 7) == 0);
        r = ($urandom_range(0, 3) != 0);
      end else begin
        v = ~tail_done;
        l = 1'b1;
        r = 1'b1;
      end
      drv_a(v, d, l, r);
      if (hold) begin
        n_cmp++; if (o_val !== 1'b1 || o_data !== hd || o_last !== hl) begin n_bad++; $display("FAIL rand_hold: got val=%b %h last=%b want val=1 %h last=%b", o_val, o_data, o_last, hd, hl); end
      end
      if (mfl) begin
        n_cmp++; if (o_urdy !== 1'b0) begin n_bad++; $display("FAIL rand_flush_rdy: got %b want 0", o_urdy); end
      end
      hold = o_val & ~r; hd = o_data; hl = o_last;
      if (f_up) begin
        model_push(32'(d), l);
        if (l) mfl = 1'b1;
        if (c >= 400) tail_done = 1'b1;
      end
      if (f_dn) begin
        n_cmp++;
        if (mexp.size() == 0) begin n_bad++; $display("FAIL rand_extra: got %h want no word", o_data); end
        else begin
          e = mexp.pop_front();
          if (o_data !== e.data || o_last !== e.last) begin n_bad++; $display("FAIL rand_word: got %h last=%b want %h last=%b", o_data, o_last, e.data, e.last); end
`ifdef STR_GBOX_CNT_EN
          n_cmp++; if (o_cnt !== e.cnt) begin n_bad++; $display("FAIL rand_cnt: got %0d want %0d", o_cnt, e.cnt); end
`endif
        end
        if (o_last) mfl = 1'b0;
      end
      if (tail_done && mexp.size() == 0 && !mfl) break;
    end
    n_cmp++; if (!tail_done || mexp.size() !== 0) begin n_bad++; $display("FAIL rand_timeout: got tail=%b pending=%0d want 1 0", tail_done, mexp.size()); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_no_stall();
    test_flush_2to8();
    test_exact_multiple();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
